// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB write-back stage: load types, write-back
// source selects and the default datapath width.
package wb_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [2:0] {
      LT_LB  = 3'b000,
      LT_LH  = 3'b001,
      LT_LW  = 3'b010,
      LT_LBU = 3'b100,
      LT_LHU = 3'b101
   } load_type_e;

   // 2'b11 is also decoded as ALU by the write-back mux
   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_PC4  = 2'b10
   } wb_sel_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-side capture bundle and register-file write port of the MEM/WB stage.
// slave = the stage itself, master = whoever drives MEM and observes WB.
interface mem_wb_stage_if #(parameter int XLEN = 32);

   logic            mem_valid;
   logic            mem_reg_write;
   logic [1:0]      mem_wb_sel;
   logic [4:0]      mem_rd;
   logic [XLEN-1:0] mem_alu_result;
   logic [XLEN-1:0] mem_load_data;
   logic [2:0]      mem_load_type;
   logic [XLEN-1:0] mem_pc_plus4;

   logic            wb_valid;
   logic            wb_reg_write;
   logic [4:0]      wb_write_addr;
   logic [XLEN-1:0] wb_write_data;
   logic            wb_misaligned;

   modport slave (
      input  mem_valid, mem_reg_write, mem_wb_sel, mem_rd, mem_alu_result,
             mem_load_data, mem_load_type, mem_pc_plus4,
      output wb_valid, wb_reg_write, wb_write_addr, wb_write_data, wb_misaligned
   );

   modport master (
      output mem_valid, mem_reg_write, mem_wb_sel, mem_rd, mem_alu_result,
             mem_load_data, mem_load_type, mem_pc_plus4,
      input  wb_valid, wb_reg_write, wb_write_addr, wb_write_data, wb_misaligned
   );

endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Load alignment and sign/zero extension from a raw memory word.
// Unknown load types behave as lw, including the misalignment check.
module load_extend
   import wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      offset,
   input  logic [2:0]      load_type,
   output logic [XLEN-1:0] data,
   output logic            misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[7:0];
      case (offset)
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         2'd3:    byte_sel = word[31:24];
         default: byte_sel = word[7:0];
      endcase
      half_sel = offset[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      data       = word;
      misaligned = 1'b0;
      case (load_type)
         LT_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LT_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
         LT_LH: begin
            data       = {{(XLEN-16){half_sel[15]}}, half_sel};
            misaligned = offset[0];
         end
         LT_LHU: begin
            data       = {{(XLEN-16){1'b0}}, half_sel};
            misaligned = offset[0];
         end
         default: begin
            data       = word;
            misaligned = (offset != 2'd0);
         end
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage driving the register file port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage
   import wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   mem_wb_stage_if.slave     bus
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0]       retire_count
`endif
);

   logic            valid_q,     valid_d;
   logic            reg_write_q, reg_write_d;
   logic [1:0]      wb_sel_q,    wb_sel_d;
   logic [4:0]      rd_q,        rd_d;
   logic [XLEN-1:0] alu_q,       alu_d;
   logic [XLEN-1:0] ld_data_q,   ld_data_d;
   logic [2:0]      ld_type_q,   ld_type_d;
   logic [XLEN-1:0] pc4_q,       pc4_d;

   logic            advance;
   logic [XLEN-1:0] ext_data;
   logic            ext_misaligned;
   logic [XLEN-1:0] wdata;

   assign advance = !stall && !flush;

   // flush wins over stall
   always_comb begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
      wb_sel_d    = wb_sel_q;
      rd_d        = rd_q;
      alu_d       = alu_q;
      ld_data_d   = ld_data_q;
      ld_type_d   = ld_type_q;
      pc4_d       = pc4_q;
      if (flush) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         wb_sel_d    = 2'b00;
         rd_d        = 5'd0;
         alu_d       = '0;
         ld_data_d   = '0;
         ld_type_d   = 3'b000;
         pc4_d       = '0;
      end else if (!stall) begin
         valid_d     = bus.mem_valid;
         reg_write_d = bus.mem_reg_write;
         wb_sel_d    = bus.mem_wb_sel;
         rd_d        = bus.mem_rd;
         alu_d       = bus.mem_alu_result;
         ld_data_d   = bus.mem_load_data;
         ld_type_d   = bus.mem_load_type;
         pc4_d       = bus.mem_pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         wb_sel_q    <= 2'b00;
         rd_q        <= 5'd0;
         alu_q       <= '0;
         ld_data_q   <= '0;
         ld_type_q   <= 3'b000;
         pc4_q       <= '0;
      end else begin
         valid_q     <= valid_d;
         reg_write_q <= reg_write_d;
         wb_sel_q    <= wb_sel_d;
         rd_q        <= rd_d;
         alu_q       <= alu_d;
         ld_data_q   <= ld_data_d;
         ld_type_q   <= ld_type_d;
         pc4_q       <= pc4_d;
      end
   end

   load_extend #(.XLEN(XLEN)) u_load_extend (
      .word       (ld_data_q),
      .offset     (alu_q[1:0]),
      .load_type  (ld_type_q),
      .data       (ext_data),
      .misaligned (ext_misaligned)
   );

   // Invalid entries present as a clean bubble regardless of captured fields
   always_comb begin
      wdata = '0;
      if (valid_q) begin
         case (wb_sel_q)
            WB_LOAD: wdata = ext_data;
            WB_PC4:  wdata = pc4_q;
            default: wdata = alu_q;
         endcase
      end
   end

   assign bus.wb_valid      = valid_q;
   assign bus.wb_reg_write  = valid_q && reg_write_q && (rd_q != 5'd0);
   assign bus.wb_write_addr = valid_q ? rd_q : 5'd0;
   assign bus.wb_write_data = wdata;
   assign bus.wb_misaligned = valid_q && (wb_sel_q == WB_LOAD) && ext_misaligned;

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt_q, retire_cnt_d;

   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (advance && bus.mem_valid) retire_cnt_d = retire_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retire_cnt_q <= 32'd0;
      else        retire_cnt_q <= retire_cnt_d;
   end

   assign retire_count = retire_cnt_q;
`else
   logic unused_advance;
   assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expectations.
// Counter checks are compiled only when WB_RETIRE_CNT_EN is defined.
module tb_mem_wb_stage;
   import wb_pkg::*;

   logic clk;
   logic rst_n;
   logic stall;
   logic flush;
   int   n_total;
   int   n_bad;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_count;
`endif

   mem_wb_stage_if #(.XLEN(32)) bus ();

   mem_wb_stage #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (stall),
      .flush (flush),
      .bus   (bus.slave)
`ifdef WB_RETIRE_CNT_EN
      ,
      .retire_count (retire_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic rw, input logic [1:0] sel,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [2:0] lt,
                         input logic [31:0] pc4);
      bus.mem_valid      = v;
      bus.mem_reg_write  = rw;
      bus.mem_wb_sel     = sel;
      bus.mem_rd         = rd;
      bus.mem_alu_result = alu;
      bus.mem_load_data  = ld;
      bus.mem_load_type  = lt;
      bus.mem_pc_plus4   = pc4;
   endtask

   // advance one edge and sample 1ns later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic we,
                          input logic [4:0] addr, input logic [31:0] data);
      chk({tag, ".valid"}, {31'd0, bus.wb_valid}, {31'd0, v});
      chk({tag, ".we"},    {31'd0, bus.wb_reg_write}, {31'd0, we});
      chk({tag, ".addr"},  {27'd0, bus.wb_write_addr}, {27'd0, addr});
      chk({tag, ".data"},  bus.wb_write_data, data);
   endtask

   task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] off,
                          input logic [31:0] exp, input logic exp_mis);
      set_in(1'b1, 1'b1, WB_LOAD, 5'd9, {30'h0000_1000, off}, 32'h80FF7F01, lt, 32'h0);
      step();
      chk({tag, ".data"}, bus.wb_write_data, exp);
      chk({tag, ".mis"},  {31'd0, bus.wb_misaligned}, {31'd0, exp_mis});
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      stall   = 1'b0;
      flush   = 1'b0;
      rst_n   = 1'b0;
      set_in(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 3'b000, 32'h0);
      #12;
      chk_out("rst", 1'b0, 1'b0, 5'd0, 32'h0);
      rst_n = 1'b1;

      // ALU write
      set_in(1'b1, 1'b1, WB_ALU, 5'd5, 32'h12345678, 32'h0, LT_LW, 32'h0);
      step();
      chk_out("alu", 1'b1, 1'b1, 5'd5, 32'h12345678);
      chk("alu.mis", {31'd0, bus.wb_misaligned}, 32'd0);

      // asynchronous reset mid-cycle, then idle after release
      #3;
      rst_n = 1'b0;
      #1;
      chk_out("rst_mid", 1'b0, 1'b0, 5'd0, 32'h0);
      set_in(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 3'b000, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk_out("idle", 1'b0, 1'b0, 5'd0, 32'h0);

      // loads with raw word 0x80FF7F01
      do_load("lb3",  LT_LB,  2'd3, 32'hFFFFFF80, 1'b0);
      do_load("lbu1", LT_LBU, 2'd1, 32'h0000007F, 1'b0);
      do_load("lh2",  LT_LH,  2'd2, 32'hFFFF80FF, 1'b0);
      do_load("lhu0", LT_LHU, 2'd0, 32'h00007F01, 1'b0);
      do_load("lh1",  LT_LH,  2'd1, 32'h00007F01, 1'b1);
      do_load("lw2",  LT_LW,  2'd2, 32'h80FF7F01, 1'b1);

      // misalignment only flagged for load-sourced write-back
      set_in(1'b1, 1'b1, WB_ALU, 5'd3, 32'h00000003, 32'h0, LT_LW, 32'h0);
      step();
      chk("alu_off.mis", {31'd0, bus.wb_misaligned}, 32'd0);

      // x0 suppression and link value
      set_in(1'b1, 1'b1, WB_ALU, 5'd0, 32'hDEADBEEF, 32'h0, LT_LW, 32'h0);
      step();
      chk("x0.we", {31'd0, bus.wb_reg_write}, 32'd0);
      set_in(1'b1, 1'b1, WB_PC4, 5'd31, 32'h0000_0044, 32'h0, LT_LW, 32'h00400008);
      step();
      chk_out("link", 1'b1, 1'b1, 5'd31, 32'h00400008);

      // stall for 3 cycles holds the link instruction
      set_in(1'b1, 1'b1, WB_ALU, 5'd7, 32'hAAAA5555, 32'h0, LT_LW, 32'h0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out($sformatf("stall%0d", i), 1'b1, 1'b1, 5'd31, 32'h00400008);
      end

      // stall together with flush inserts a bubble
      flush = 1'b1;
      step();
      chk_out("stflush", 1'b0, 1'b0, 5'd0, 32'h0);
      stall = 1'b0;
      flush = 1'b0;
      step();
      chk_out("after_flush", 1'b1, 1'b1, 5'd7, 32'hAAAA5555);

      // reset during a stall discards the held instruction
      stall = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("rst_stall", 1'b0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk_out("rst_stall_held", 1'b0, 1'b0, 5'd0, 32'h0);
      stall = 1'b0;

`ifdef WB_RETIRE_CNT_EN
      // counter starts from zero after the reset above
      chk("cnt.rst", retire_count, 32'd0);
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 1'b1, WB_ALU, 5'(i + 1), 32'(i), 32'h0, LT_LW, 32'h0);
         flush = (i == 2);
         step();
      end
      flush = 1'b0;
      set_in(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 3'b000, 32'h0);
      step();
      chk("cnt.4of5", retire_count, 32'd4);

      // wrap past 0xFFFFFFFF
      #2;
      force dut.retire_cnt_q = 32'hFFFFFFFF;
      #1;
      release dut.retire_cnt_q;
      set_in(1'b1, 1'b1, WB_ALU, 5'd2, 32'h1, 32'h0, LT_LW, 32'h0);
      step();
      chk("cnt.wrap0", retire_count, 32'h00000000);
      step();
      chk("cnt.wrap1", retire_count, 32'h00000001);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got still running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and write-back stage of the five-stage CPU. It captures memory-stage results on each clock edge, aligns and extends load data, selects the write-back source, and drives the register file write port (write enable, address, data). It is the producer for the register file write port and for the WB forwarding path.

## Interface
Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold the MEM/WB register contents.
- flush  in  1  replace the captured instruction with a bubble.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_reg_write  in  1  instruction writes rd.
- mem_wb_sel  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 ALU.
- mem_rd  in  5  destination register.
- mem_alu_result  in  XLEN  ALU result; bits [1:0] are the load byte offset.
- mem_load_data  in  XLEN  raw word read from data memory.
- mem_load_type  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; others treated as lw.
- mem_pc_plus4  in  XLEN  link value for jal/jalr.
- wb_valid  out  1  WB register holds a real instruction.
- wb_reg_write  out  1  register file write enable.
- wb_write_addr  out  5  register file write address.
- wb_write_data  out  XLEN  register file write data.
- wb_misaligned  out  1  lh/lhu at odd offset or lw at nonzero offset.
- retire_count  out  32  retired-instruction count (only with WB_RETIRE_CNT_EN).

## Operation
- Capture: on rising clk, if flush, WB register loads a bubble (valid=0, reg_write=0, rd=0, data fields 0); else if stall, hold; else load all mem_* inputs.
- flush has priority over stall.
- wb_reg_write = reg valid AND reg reg_write AND rd != 0. Writes to x0 never reach the register file.
- wb_write_addr = registered rd; wb_write_data per registered wb_sel.
- Load extension (combinational from registered fields, offset = alu_result[1:0]):
  - lb/lbu: byte at offset; sign- or zero-extend to XLEN.
  - lh/lhu: halfword at offset[1] (offset[0] ignored); sign- or zero-extend.
  - lw: full word; offset ignored.
- wb_misaligned asserted only when valid AND wb_sel=01; data still produced as above.
- Bubble outputs: wb_valid=0, wb_reg_write=0, wb_write_addr=0, wb_write_data=0.

## Timing
- Latency: one cycle, MEM inputs at edge N appear on wb_* outputs after edge N.
- wb_* outputs are combinational from the WB register only; no input-to-output paths.
- Reset (rst_n low, asynchronous): WB register cleared to bubble; all outputs 0; retire_count 0. Reset mid-stall discards the held instruction.
- Stall for K cycles: outputs constant for K cycles; the register file rewrites the same value, which is idempotent.
- Simultaneous stall and flush: bubble inserted.
- Register file write occurs at the edge after wb_* are valid. The register file performs write-before-read bypass, so no extra forwarding is needed in this block.

## Configuration
- WB_RETIRE_CNT_EN defined: 32-bit retire_count increments on each edge where the register advances (no stall, no flush) and mem_valid=1. Bubbles are not counted. The counter wraps 0xFFFFFFFF to 0, and the new value is visible after the capturing edge.
- Undefined: retire_count port and counter logic absent.

## Structure
- Package wb_pkg: load-type codes (LT_LB, LT_LH, LT_LW, LT_LBU, LT_LHU), wb_sel codes (WB_ALU, WB_LOAD, WB_PC4), XLEN default.
- Sub-module load_extend: combinational inputs word, offset, load type; outputs extended data and misaligned flag.
- Top level holds the WB register, source mux, x0 suppression, and the optional counter.

## Test plan
- Reset: rst_n low mid-cycle -> all outputs 0 immediately; after release with no valid input, outputs remain 0.
- ALU write: mem_valid=1, reg_write=1, rd=5, sel=00, alu=0x12345678 -> next cycle wb_reg_write=1, addr=5, data=0x12345678.
- Loads with load_data=0x80FF7F01:
  - lb at offset 3 -> 0xFFFFFF80.
  - lbu at offset 1 -> 0x0000007F.
  - lh at offset 2 -> 0xFFFF80FF.
  - lhu at offset 0 -> 0x00007F01.
  - lh at offset 1 -> wb_misaligned=1, data 0x00007F01.
- x0 and link: rd=0, reg_write=1 -> wb_reg_write=0; sel=10, pc_plus4=0x00400008, rd=31 -> data 0x00400008.
- Stall/flush: stall 3 cycles -> outputs held 3 cycles. stall and flush together -> bubble. Counter counts 4 of 5 issued instructions when one is flushed.
- Counter wrap (WB_RETIRE_CNT_EN): counter forced near 0xFFFFFFFF, two valid captures -> 0x00000000 then 0x00000001.
